// File: rtl/idma_backend_chan_sched_pkg.sv
// Shared types for the iDMA backend channel scheduler: arbiter states and default
// request/response payload types.
package idma_backend_chan_sched_pkg;

    typedef enum logic [0:0] {
        StArb,
        StHold
    } idma_sched_state_e;

    typedef logic [31:0] sched_req_t;

    typedef struct packed {
        logic [7:0] id;
        logic       error;
    } sched_rsp_t;

endpackage

// File: rtl/idma_backend_chan_sched_fifo.sv
// In-order route FIFO holding the channel index of every request the backend has accepted
// but not yet answered. No fall-through: data_o shows the oldest stored entry.
module idma_backend_chan_sched_fifo #(
    parameter int unsigned DataWidth = 2,
    parameter int unsigned Depth     = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 pop_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 full_o,
    output logic                 empty_o
);
    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

    logic [DataWidth-1:0] mem_q [Depth];
    logic [PtrWidth-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrWidth:0]    cnt_q;
    logic                 push_en, pop_en;

    assign full_o  = (cnt_q == (PtrWidth + 1)'(Depth));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign push_en = push_i & ~full_o;
    assign pop_en  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= (wr_ptr_q == PtrWidth'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_q <= (rd_ptr_q == PtrWidth'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push_en && !pop_en) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop_en && !push_en) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/idma_backend_chan_sched.sv
// Round-robin scheduler sharing one iDMA backend between NumChan frontend channels, with
// in-order response routing and per-channel completion/error counters.
module idma_backend_chan_sched
    import idma_backend_chan_sched_pkg::*;
#(
    parameter int unsigned NumChan        = 4,
    parameter int unsigned NumOutstanding = 8,
    parameter int unsigned CntWidth       = 16,
    parameter type         idma_req_t     = sched_req_t,
    parameter type         idma_rsp_t     = sched_rsp_t
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  idma_req_t [NumChan-1:0]            req_i,
    input  logic      [NumChan-1:0]            req_valid_i,
    output logic      [NumChan-1:0]            req_ready_o,
    output idma_rsp_t                          rsp_o,
    output logic      [NumChan-1:0]            rsp_valid_o,
    input  logic      [NumChan-1:0]            rsp_ready_i,
    output idma_req_t                          be_req_o,
    output logic                               be_req_valid_o,
    input  logic                               be_req_ready_i,
    input  idma_rsp_t                          be_rsp_i,
    input  logic                               be_rsp_valid_i,
    output logic                               be_rsp_ready_o,
    output logic      [NumChan-1:0][CntWidth-1:0] done_cnt_o,
    output logic      [NumChan-1:0][CntWidth-1:0] err_cnt_o,
    output logic                               busy_o
);
    localparam int unsigned ChanIdxWidth = $clog2(NumChan);

    idma_sched_state_e                state_q;
    logic [ChanIdxWidth-1:0]          grant_q, rr_ptr_q, arb_grant, cand, grant, head;
    logic                             arb_found, fifo_full, fifo_empty, req_hs, rsp_hs;
    logic [NumChan-1:0][CntWidth-1:0] done_cnt_q, err_cnt_q;

    // First valid channel at or after rr_ptr_q, in circular order.
    always_comb begin
        arb_grant = '0;
        arb_found = 1'b0;
        cand      = '0;
        for (int unsigned k = 0; k < NumChan; k++) begin
            cand = ChanIdxWidth'((32'(rr_ptr_q) + k) % NumChan);
            if (!arb_found && req_valid_i[cand]) begin
                arb_found = 1'b1;
                arb_grant = cand;
            end
        end
    end

    assign grant          = (state_q == StHold) ? grant_q : arb_grant;
    assign be_req_o       = req_i[grant];
    assign be_req_valid_o = ~fifo_full & ((state_q == StHold) ? req_valid_i[grant_q] : arb_found);
    assign req_hs         = be_req_valid_o & be_req_ready_i;

    always_comb begin
        req_ready_o        = '0;
        req_ready_o[grant] = req_hs;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= StArb;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else if (req_hs) begin
            state_q  <= StArb;
            rr_ptr_q <= (grant == ChanIdxWidth'(NumChan - 1)) ? '0 : grant + 1'b1;
        end else if (be_req_valid_o) begin
            state_q <= StHold;
            grant_q <= grant;
        end else begin
            // Also covers a held channel dropping valid: back to arbitration, pointer untouched.
            state_q <= StArb;
        end
    end

    idma_backend_chan_sched_fifo #(
        .DataWidth (ChanIdxWidth),
        .Depth     (NumOutstanding)
    ) i_route_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (req_hs),
        .data_i  (grant),
        .pop_i   (rsp_hs),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign rsp_o          = be_rsp_i;
    assign be_rsp_ready_o = ~fifo_empty & rsp_ready_i[head];
    assign rsp_hs         = be_rsp_valid_i & be_rsp_ready_o;

    always_comb begin
        rsp_valid_o       = '0;
        rsp_valid_o[head] = be_rsp_valid_i & ~fifo_empty;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            done_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else if (rsp_hs) begin
            done_cnt_q[head] <= done_cnt_q[head] + 1'b1;
            if (be_rsp_i.error) begin
                err_cnt_q[head] <= err_cnt_q[head] + 1'b1;
            end
        end
    end

    assign done_cnt_o = done_cnt_q;
    assign err_cnt_o  = err_cnt_q;
    assign busy_o     = be_req_valid_o | ~fifo_empty;

    // A response with nothing outstanding is a backend protocol violation.
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(be_rsp_valid_i && fifo_empty))
        else $error("backend response with no outstanding request");

endmodule
